// File: rtl/interrupt_sequencer.sv
// Fixed-priority 8-level interrupt sequencer in the style of the 8259A.
// Collects requests, raises INT, runs the two-pulse acknowledge and returns the vector.
module interrupt_sequencer (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] IR,
    input  logic [7:0] IMR,
    input  logic       LTIM,
    input  logic [4:0] VBASE,
    input  logic       AEOI,
    input  logic       INTA_N,
    input  logic       EOI_CMD,
    input  logic       EOI_SPEC,
    input  logic [2:0] EOI_LVL,
    output logic       INT,
    output logic [7:0] IRR,
    output logic [7:0] ISR,
    output logic [7:0] DOUT,
    output logic       DOUT_EN
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACK1  = 2'd1;
    localparam logic [1:0] WAIT2 = 2'd2;
    localparam logic [1:0] ACK2  = 2'd3;

    logic [1:0] state_q, state_d;
    logic [2:0] lvl_q, lvl_d;
    logic       spurious_q, spurious_d;
    logic [7:0] irr_q, irr_d;
    logic [7:0] isr_q, isr_d;
    logic       int_q, int_d;
    logic [7:0] dout_q, dout_d;
    logic       dout_en_q, dout_en_d;
    logic [7:0] prev_ir_q;
    logic [7:0] edge_q;
    logic       prev_inta_q;

    logic       inta_fall, inta_rise;
    logic [7:0] pending;
    logic       has_winner;
    logic [2:0] winner;
    logic [2:0] isr_top;
    logic       int_cond;
    logic [7:0] ack_set, aeoi_clr, eoi_clr;

    // Index of the lowest set bit; 0 when the vector is empty (callers qualify).
    function automatic logic [2:0] lowest_index(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    assign inta_fall  = prev_inta_q & ~INTA_N;
    assign inta_rise  = ~prev_inta_q & INTA_N;
    assign pending    = irr_q & ~IMR;
    assign has_winner = |pending;
    assign winner     = lowest_index(pending);
    assign isr_top    = lowest_index(isr_q);
    assign int_cond   = has_winner && ((isr_q == 8'd0) || (winner < isr_top));

    // NOTE: every signal driven here gets a default first, so no path leaves a latch.
    always_comb begin
        state_d    = state_q;
        lvl_d      = lvl_q;
        spurious_d = spurious_q;
        ack_set    = 8'd0;
        aeoi_clr   = 8'd0;
        case (state_q)
            IDLE: begin
                if (inta_fall) begin
                    state_d = ACK1;
                    if (has_winner) begin
                        lvl_d      = winner;
                        spurious_d = 1'b0;
                        ack_set    = 8'd1 << winner;
                    end else begin
                        lvl_d      = 3'd7;
                        spurious_d = 1'b1;
                    end
                end
            end
            ACK1: begin
                if (inta_rise) state_d = WAIT2;
            end
            WAIT2: begin
                if (inta_fall) state_d = ACK2;
            end
            ACK2: begin
                if (inta_rise) begin
                    state_d = IDLE;
                    if (AEOI && !spurious_q) aeoi_clr = 8'd1 << lvl_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        eoi_clr = 8'd0;
        if (EOI_CMD) begin
            // Two's-complement trick isolates the highest-priority in-service bit.
            eoi_clr = EOI_SPEC ? (8'd1 << EOI_LVL) : (isr_q & (~isr_q + 8'd1));
        end
    end

    // Clears act on the registered ISR first, then the acknowledge set is OR-ed in.
    assign isr_d = (isr_q & ~eoi_clr & ~aeoi_clr) | ack_set;
    assign irr_d = LTIM ? (IR & ~ack_set) : ((irr_q | edge_q) & ~ack_set);

    // INT is only asserted while the FSM stays idle this cycle.
    assign int_d     = (state_q == IDLE) && !inta_fall && int_cond;
    assign dout_en_d = (state_d == ACK2);
    assign dout_d    = dout_en_d ? {VBASE, lvl_q} : 8'd0;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            lvl_q       <= 3'd0;
            spurious_q  <= 1'b0;
            irr_q       <= 8'd0;
            isr_q       <= 8'd0;
            int_q       <= 1'b0;
            dout_q      <= 8'd0;
            dout_en_q   <= 1'b0;
            prev_ir_q   <= 8'hFF;
            edge_q      <= 8'd0;
            prev_inta_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            lvl_q       <= lvl_d;
            spurious_q  <= spurious_d;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            int_q       <= int_d;
            dout_q      <= dout_d;
            dout_en_q   <= dout_en_d;
            prev_ir_q   <= IR;
            edge_q      <= IR & ~prev_ir_q;
            prev_inta_q <= INTA_N;
        end
    end

    assign INT     = int_q;
    assign IRR     = irr_q;
    assign ISR     = isr_q;
    assign DOUT    = dout_q;
    assign DOUT_EN = dout_en_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Directed bench for interrupt_sequencer: hand-computed expectations, sampled 1 ns after each rising edge.
module tb_interrupt_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] IR;
    logic [7:0] IMR;
    logic       LTIM;
    logic [4:0] VBASE;
    logic       AEOI;
    logic       INTA_N;
    logic       EOI_CMD;
    logic       EOI_SPEC;
    logic [2:0] EOI_LVL;
    logic       INT;
    logic [7:0] IRR;
    logic [7:0] ISR;
    logic [7:0] DOUT;
    logic       DOUT_EN;

    int tests_run = 0;
    int tests_failed = 0;

    interrupt_sequencer dut (
        .CLK(CLK), .RST(RST), .IR(IR), .IMR(IMR), .LTIM(LTIM), .VBASE(VBASE),
        .AEOI(AEOI), .INTA_N(INTA_N), .EOI_CMD(EOI_CMD), .EOI_SPEC(EOI_SPEC),
        .EOI_LVL(EOI_LVL), .INT(INT), .IRR(IRR), .ISR(ISR), .DOUT(DOUT), .DOUT_EN(DOUT_EN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 8'h%02h expected 8'h%02h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic eoi(input logic spec, input logic [2:0] lvl);
        EOI_CMD = 1'b1; EOI_SPEC = spec; EOI_LVL = lvl;
        step(1);
        EOI_CMD = 1'b0; EOI_SPEC = 1'b0; EOI_LVL = 3'd0;
    endtask

    task automatic ack_full(input string tag, input logic [7:0] exp_vec);
        INTA_N = 1'b0; step(1);
        INTA_N = 1'b1; step(1);
        INTA_N = 1'b0; step(1);
        check({tag, "_dout"}, DOUT, exp_vec);
        check({tag, "_douten"}, {7'd0, DOUT_EN}, 8'd1);
        INTA_N = 1'b1; step(1);
        check({tag, "_douten_off"}, {7'd0, DOUT_EN}, 8'd0);
    endtask

    initial begin
        RST = 1'b1; IR = 8'h00; IMR = 8'h00; LTIM = 1'b0; VBASE = 5'h08; AEOI = 1'b0;
        INTA_N = 1'b1; EOI_CMD = 1'b0; EOI_SPEC = 1'b0; EOI_LVL = 3'd0;
        step(2);
        RST = 1'b0;
        step(1);
        check("rst_int", {7'd0, INT}, 8'h00);
        check("rst_irr", IRR, 8'h00);
        check("rst_isr", ISR, 8'h00);
        check("rst_dout", DOUT, 8'h00);
        check("rst_douten", {7'd0, DOUT_EN}, 8'h00);

        // Edge mode, IR3: IRR one edge after detection, INT the edge after that.
        IR = 8'h08;
        step(1);
        check("e3_irr_n", IRR, 8'h00);
        step(1);
        check("e3_irr_n1", IRR, 8'h08);
        check("e3_int_n1", {7'd0, INT}, 8'h00);
        step(1);
        check("e3_int_n2", {7'd0, INT}, 8'h01);
        IR = 8'h00;
        INTA_N = 1'b0; step(1);
        check("e3_ack1_isr", ISR, 8'h08);
        check("e3_ack1_irr", IRR, 8'h00);
        check("e3_ack1_int", {7'd0, INT}, 8'h00);
        INTA_N = 1'b1; step(1);
        INTA_N = 1'b0; step(1);
        check("e3_dout", DOUT, 8'h43);
        check("e3_douten", {7'd0, DOUT_EN}, 8'h01);
        INTA_N = 1'b1; step(1);
        check("e3_end_dout", DOUT, 8'h00);
        check("e3_end_douten", {7'd0, DOUT_EN}, 8'h00);
        check("e3_end_isr", ISR, 8'h08);

        // Nesting behind ISR[3]: IR5 blocked, IR1 preempts.
        IR = 8'h20;
        step(3);
        check("nest_irr5", IRR, 8'h20);
        check("nest_int5", {7'd0, INT}, 8'h00);
        IR = 8'h22;
        step(3);
        check("nest_int1", {7'd0, INT}, 8'h01);
        ack_full("nest_ack1", 8'h41);
        check("nest_isr", ISR, 8'h0A);
        check("nest_irr", IRR, 8'h20);
        eoi(1'b0, 3'd0);
        check("nest_nseoi", ISR, 8'h08);
        step(1);
        check("nest_int_blk", {7'd0, INT}, 8'h00);
        eoi(1'b1, 3'd3);
        check("nest_seoi3", ISR, 8'h00);
        step(1);
        check("nest_int5_go", {7'd0, INT}, 8'h01);
        IR = 8'h00;
        ack_full("nest_ack5", 8'h45);
        check("nest_isr5", ISR, 8'h20);
        eoi(1'b0, 3'd0);
        check("nest_clr", ISR, 8'h00);

        // AEOI: ISR[6] clears on the second rising INTA_N edge; pending IR7 raises INT next idle cycle.
        AEOI = 1'b1;
        IR = 8'h40;
        step(3);
        check("aeoi_int", {7'd0, INT}, 8'h01);
        IR = 8'h00;
        INTA_N = 1'b0; step(1);
        check("aeoi_isr_set", ISR, 8'h40);
        INTA_N = 1'b1; step(1);
        IR = 8'h80;
        INTA_N = 1'b0; step(1);
        check("aeoi_dout", DOUT, 8'h46);
        check("aeoi_isr_ack2", ISR, 8'h40);
        INTA_N = 1'b1; step(1);
        check("aeoi_isr_clr", ISR, 8'h00);
        check("aeoi_irr7", IRR, 8'h80);
        check("aeoi_int_low", {7'd0, INT}, 8'h00);
        step(1);
        check("aeoi_int_reeval", {7'd0, INT}, 8'h01);
        IR = 8'h00;
        ack_full("aeoi_ack7", 8'h47);
        check("aeoi_isr7", ISR, 8'h00);
        AEOI = 1'b0;

        // Spurious: level-mode IR2 withdrawn before acknowledge.
        LTIM = 1'b1;
        IR = 8'h04;
        step(1);
        check("spur_irr", IRR, 8'h04);
        step(1);
        check("spur_int", {7'd0, INT}, 8'h01);
        IR = 8'h00;
        step(2);
        check("spur_int_drop", {7'd0, INT}, 8'h00);
        ack_full("spur_ack", 8'h47);
        check("spur_isr", ISR, 8'h00);
        check("spur_irr0", IRR, 8'h00);

        // Specific EOI on level 3 in the cycle ISR[3] is set: set wins.
        IR = 8'h08;
        step(2);
        check("same_int", {7'd0, INT}, 8'h01);
        INTA_N = 1'b0; EOI_CMD = 1'b1; EOI_SPEC = 1'b1; EOI_LVL = 3'd3;
        step(1);
        EOI_CMD = 1'b0; EOI_SPEC = 1'b0; EOI_LVL = 3'd0; IR = 8'h00;
        check("same_isr", ISR, 8'h08);
        check("same_irr", IRR, 8'h00);
        INTA_N = 1'b1; step(1);
        INTA_N = 1'b0; step(1);
        check("same_dout", DOUT, 8'h43);
        INTA_N = 1'b1; step(1);
        eoi(1'b1, 3'd5);
        check("seoi_clear_bit", ISR, 8'h08);
        eoi(1'b0, 3'd0);
        check("nseoi_last", ISR, 8'h00);
        eoi(1'b0, 3'd0);
        check("nseoi_empty", ISR, 8'h00);

        // Reset in WAIT2 aborts; IR4 held through reset in edge mode stays silent.
        IR = 8'h10;
        step(2);
        check("rstw_int", {7'd0, INT}, 8'h01);
        INTA_N = 1'b0; step(1);
        INTA_N = 1'b1; step(1);
        check("rstw_isr", ISR, 8'h10);
        RST = 1'b1; INTA_N = 1'b0; LTIM = 1'b0;
        step(1);
        RST = 1'b0; INTA_N = 1'b1;
        check("rstw_int0", {7'd0, INT}, 8'h00);
        check("rstw_irr0", IRR, 8'h00);
        check("rstw_isr0", ISR, 8'h00);
        check("rstw_dout0", DOUT, 8'h00);
        check("rstw_douten0", {7'd0, DOUT_EN}, 8'h00);
        step(4);
        check("held_int", {7'd0, INT}, 8'h00);
        check("held_irr", IRR, 8'h00);
        check("held_douten", {7'd0, DOUT_EN}, 8'h00);

        // Fresh edge after reset works; masking after INT drops it next cycle.
        IR = 8'h00; step(1);
        IR = 8'h10; step(3);
        check("post_int", {7'd0, INT}, 8'h01);
        check("post_irr", IRR, 8'h10);
        IMR = 8'h10;
        step(1);
        check("mask_int", {7'd0, INT}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
